// File: rtl/input_wrapper_if.sv
// Handshake/bus bundle between the serial source, the input wrapper and the core.
// The wrapper uses the slave modport; whoever drives the serial stream uses master.
interface input_wrapper_if #(
  parameter int WIDTH = 32
);
  logic             serIn;
  logic             serValid;
  logic             coreReady;
  logic [WIDTH-1:0] outBus;
  logic             start;
  logic             gotData;
  logic             iBufferEmpty;
  logic             iBufferFull;

  modport slave (
    input  serIn, serValid, coreReady,
    output outBus, start, gotData, iBufferEmpty, iBufferFull
  );

  modport master (
    output serIn, serValid, coreReady,
    input  outBus, start, gotData, iBufferEmpty, iBufferFull
  );
endinterface

// File: rtl/input_wrapper.sv
// MSB-first serial-to-parallel front end: collects a WIDTH-bit word, acknowledges it
// with a two-cycle gotData pulse, then launches the core with a one-cycle start.
module input_wrapper #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic           clk,
  input  logic           rst,
  input_wrapper_if.slave bus
);

  typedef enum logic [2:0] {
    S_EMPTY,
    S_RECEIVE,
    S_ACK1,
    S_ACK2,
    S_ISSUE,
    S_LAUNCH
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_hold;
  logic [CNT_W-1:0] r_cnt;
  logic             r_start;
  logic             r_got;
  logic             r_full;
  logic             r_empty;

  logic [WIDTH-1:0] w_shift_in;
  logic             w_last_bit;

  assign w_shift_in = {r_shift[WIDTH-2:0], bus.serIn};
  assign w_last_bit = (r_cnt == CNT_W'(WIDTH - 1));

  // Output flags are registered alongside the state so each matches the state it decodes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_EMPTY;
      r_shift <= '0;
      r_hold  <= '0;
      r_cnt   <= '0;
      r_start <= 1'b0;
      r_got   <= 1'b0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (bus.serValid) begin
            r_shift <= w_shift_in;
            r_cnt   <= CNT_W'(1);
            r_empty <= 1'b0;
            r_state <= S_RECEIVE;
          end
        end
        S_RECEIVE: begin
          if (bus.serValid) begin
            r_shift <= w_shift_in;
            if (w_last_bit) begin
              r_hold  <= w_shift_in;
              r_cnt   <= '0;
              r_got   <= 1'b1;
              r_full  <= 1'b1;
              r_state <= S_ACK1;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_ACK1: begin
          r_state <= S_ACK2;
        end
        S_ACK2: begin
          r_got   <= 1'b0;
          r_state <= S_ISSUE;
        end
        S_ISSUE: begin
          if (bus.coreReady) begin
            r_start <= 1'b1;
            r_state <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_start <= 1'b0;
          r_full  <= 1'b0;
          r_empty <= 1'b1;
          r_state <= S_EMPTY;
        end
        default: begin
          r_start <= 1'b0;
          r_got   <= 1'b0;
          r_full  <= 1'b0;
          r_empty <= 1'b1;
          r_state <= S_EMPTY;
        end
      endcase
    end
  end

  assign bus.outBus       = r_hold;
  assign bus.start        = r_start;
  assign bus.gotData      = r_got;
  assign bus.iBufferFull  = r_full;
  assign bus.iBufferEmpty = r_empty;

endmodule

// File: tb/tb_input_wrapper.sv
// Directed plus randomized bench for input_wrapper; the reference is a bit queue
// assembled into a word and a transaction timeline of ack, issue and launch cycles.
module tb_input_wrapper;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  input_wrapper_if #(.WIDTH(32)) bus_if ();

  input_wrapper #(.WIDTH(32), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic junk();
    bus_if.serValid = 1'($urandom_range(0, 1));
    bus_if.serIn    = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    bus_if.serValid = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  // Sends one word (gap_mode 0: none, 1: 3-cycle gaps after bits 0/15/30, 2: random gaps),
  // then walks the expected ack/issue/launch timeline with junk on the serial input.
  task automatic run_word(input logic [31:0] w, input int gap_mode, input int rdy_delay,
                          input string tag);
    logic        q_bits[$];
    logic [31:0] exp_w;
    int          gaplen;
    bus_if.coreReady = 1'b0;
    for (int j = 0; j < 32; j++) begin
      bus_if.serValid = 1'b1;
      bus_if.serIn    = w[31-j];
      q_bits.push_back(w[31-j]);
      tick();
      if (j < 31) begin
        chk({tag, " rx_empty"}, {31'd0, bus_if.iBufferEmpty}, 32'd0);
        chk({tag, " rx_got"}, {31'd0, bus_if.gotData}, 32'd0);
      end
      gaplen = 0;
      if (gap_mode == 1 && (j == 0 || j == 15 || j == 30)) gaplen = 3;
      else if (gap_mode == 2 && j < 31 && $urandom_range(0, 3) == 0) gaplen = $urandom_range(1, 3);
      for (int g = 0; g < gaplen; g++) begin
        bus_if.serValid = 1'b0;
        bus_if.serIn    = 1'($urandom_range(0, 1));
        tick();
        chk({tag, " gap_full"}, {31'd0, bus_if.iBufferFull}, 32'd0);
      end
    end
    exp_w = '0;
    foreach (q_bits[k]) exp_w = {exp_w[30:0], q_bits[k]};

    if (rdy_delay == 0) bus_if.coreReady = 1'b1;
    junk();
    chk({tag, " ack1_got"}, {31'd0, bus_if.gotData}, 32'd1);
    chk({tag, " ack1_full"}, {31'd0, bus_if.iBufferFull}, 32'd1);
    chk({tag, " ack1_bus"}, bus_if.outBus, exp_w);
    tick();
    junk();
    chk({tag, " ack2_got"}, {31'd0, bus_if.gotData}, 32'd1);
    chk({tag, " ack2_start"}, {31'd0, bus_if.start}, 32'd0);
    tick();
    junk();
    chk({tag, " issue_got"}, {31'd0, bus_if.gotData}, 32'd0);
    chk({tag, " issue_full"}, {31'd0, bus_if.iBufferFull}, 32'd1);
    for (int k = 0; k < rdy_delay; k++) begin
      tick();
      junk();
      chk({tag, " wait_start"}, {31'd0, bus_if.start}, 32'd0);
      chk({tag, " wait_full"}, {31'd0, bus_if.iBufferFull}, 32'd1);
      chk({tag, " wait_bus"}, bus_if.outBus, exp_w);
    end
    bus_if.coreReady = 1'b1;
    tick();
    junk();
    bus_if.coreReady = 1'($urandom_range(0, 1));
    chk({tag, " launch_start"}, {31'd0, bus_if.start}, 32'd1);
    chk({tag, " launch_full"}, {31'd0, bus_if.iBufferFull}, 32'd1);
    chk({tag, " launch_bus"}, bus_if.outBus, exp_w);
    tick();
    bus_if.serValid  = 1'b0;
    bus_if.coreReady = 1'b0;
    chk({tag, " empty_flag"}, {31'd0, bus_if.iBufferEmpty}, 32'd1);
    chk({tag, " empty_start"}, {31'd0, bus_if.start}, 32'd0);
    chk({tag, " empty_full"}, {31'd0, bus_if.iBufferFull}, 32'd0);
    chk({tag, " hold_bus"}, bus_if.outBus, exp_w);
    $display("word %s sent=%h outBus=%h rdy_delay=%0d", tag, w, bus_if.outBus, rdy_delay);
  endtask

  initial begin
    logic [31:0] rw;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    bus_if.serValid  = 1'b1;
    bus_if.serIn     = 1'b1;
    bus_if.coreReady = 1'b1;

    tick();
    tick();
    chk("rst_empty", {31'd0, bus_if.iBufferEmpty}, 32'd1);
    chk("rst_full", {31'd0, bus_if.iBufferFull}, 32'd0);
    chk("rst_got", {31'd0, bus_if.gotData}, 32'd0);
    chk("rst_start", {31'd0, bus_if.start}, 32'd0);
    chk("rst_bus", bus_if.outBus, 32'd0);
    $display("reset held: empty=%0b bus=%h", bus_if.iBufferEmpty, bus_if.outBus);
    rst = 1'b1;

    run_word(32'hA5A5_0F0F, 0, 0, "basic");
    idle(2);
    run_word(32'h8000_0001, 1, 0, "gapped");
    idle(1);
    run_word(32'h1234_5678, 0, 10, "backpressure");
    run_word($urandom, 0, 0, "after_bp");
    idle(3);

    // Abort a word mid-stream with an asynchronous reset pulse.
    for (int j = 0; j < 17; j++) begin
      bus_if.serValid = 1'b1;
      bus_if.serIn    = 1'($urandom_range(0, 1));
      tick();
    end
    bus_if.serValid = 1'b0;
    rst = 1'b0;
    #1;
    chk("async_rst_empty", {31'd0, bus_if.iBufferEmpty}, 32'd1);
    chk("async_rst_bus", bus_if.outBus, 32'd0);
    tick();
    rst = 1'b1;
    $display("mid-word reset applied after 17 bits");
    run_word(32'hFFFF_FFFF, 0, 0, "post_reset");

    run_word(32'h0000_0001, 0, 0, "b2b_a");
    run_word(32'hFFFF_FFFE, 0, 0, "b2b_b");

    for (int n = 0; n < 6; n++) begin
      rw = $urandom;
      run_word(rw, 2, $urandom_range(0, 5), "random");
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
